// File: rtl/dma_priority_arb.sv
// Priority resolver and CPU hold handshake for a four-channel 8237A-style DMA controller.
// Synchronizes DREQ, arbitrates fixed or rotating priority and holds one grant per bus tenure.
module dma_priority_arb #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic [3:0] MASK,
  input  logic [3:0] SW_REQ,
  input  logic       CMD_DISABLE,
  input  logic       CMD_ROT_PRIO,
  input  logic       DREQ_SENSE_LOW,
  input  logic       DACK_SENSE_HIGH,
  input  logic       SVC_DONE,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] CH_ACTIVE,
  output logic       CH_VALID,
  output logic [3:0] REQ_STATUS,
  output logic [3:0] SW_REQ_CLR,
  output logic [1:0] DBG_STATE
);

  // Handshake: HRQ is held until the CPU answers with HLDA; a grant lives for the whole
  // HLDA tenure and ends on SVC_DONE (normal) or HLDA falling (abort).
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-2:0][3:0] r_sync_raw;
  logic [3:0] r_req_status;
  logic       r_hrq,       w_hrq_nxt;
  logic [3:0] r_grant,     w_grant_nxt;
  logic [1:0] r_ch_active, w_ch_active_nxt;
  logic       r_ch_valid,  w_ch_valid_nxt;
  logic [1:0] r_ptr,       w_ptr_nxt;
  logic [3:0] r_sw_clr,    w_sw_clr_nxt;

  logic [3:0] w_req_eff;
  logic [1:0] w_ptr_eff;
  logic [1:0] w_idx;
  logic [1:0] w_win_ch;
  logic       w_win_found;

  // Polarity is folded into the last stage so the reset value reads as inactive.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync_raw   <= '0;
      r_req_status <= '0;
    end else begin
      r_sync_raw[0] <= DREQ;
      for (int k = 1; k < SYNC_STAGES - 1; k++) begin
        r_sync_raw[k] <= r_sync_raw[k-1];
      end
      r_req_status <= r_sync_raw[SYNC_STAGES-2] ^ {4{DREQ_SENSE_LOW}};
    end
  end

  assign w_req_eff = (r_req_status & ~MASK) | SW_REQ;
  assign w_ptr_eff = CMD_ROT_PRIO ? r_ptr : 2'd0;

  always_comb begin
    w_win_found = 1'b0;
    w_win_ch    = 2'd0;
    w_idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = w_ptr_eff + 2'(k);
      if (!w_win_found && w_req_eff[w_idx]) begin
        w_win_found = 1'b1;
        w_win_ch    = w_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_hrq       <= 1'b0;
      r_grant     <= '0;
      r_ch_active <= '0;
      r_ch_valid  <= 1'b0;
      r_ptr       <= '0;
      r_sw_clr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hrq       <= w_hrq_nxt;
      r_grant     <= w_grant_nxt;
      r_ch_active <= w_ch_active_nxt;
      r_ch_valid  <= w_ch_valid_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sw_clr    <= w_sw_clr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hrq_nxt       = r_hrq;
    w_grant_nxt     = r_grant;
    w_ch_active_nxt = r_ch_active;
    w_ch_valid_nxt  = r_ch_valid;
    w_ptr_nxt       = CMD_ROT_PRIO ? r_ptr : 2'd0;
    w_sw_clr_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (!CMD_DISABLE && (w_req_eff != 4'd0)) begin
          w_hrq_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (HLDA) begin
          // Arbitration happens here, so late higher-priority requests still win.
          if (w_win_found) begin
            w_grant_nxt     = 4'b0001 << w_win_ch;
            w_ch_active_nxt = w_win_ch;
            w_ch_valid_nxt  = 1'b1;
            w_state_nxt     = S_GRANT;
          end else begin
            w_hrq_nxt   = 1'b0;
            w_state_nxt = S_RELEASE;
          end
        end else if ((w_req_eff == 4'd0) || CMD_DISABLE) begin
          w_hrq_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (SVC_DONE) begin
          w_grant_nxt    = '0;
          w_ch_valid_nxt = 1'b0;
          w_hrq_nxt      = 1'b0;
          w_sw_clr_nxt   = SW_REQ & r_grant;
          if (CMD_ROT_PRIO) begin
            w_ptr_nxt = r_ch_active + 2'd1;
          end
          w_state_nxt = S_RELEASE;
        end else if (!HLDA) begin
          w_grant_nxt    = '0;
          w_ch_valid_nxt = 1'b0;
          w_hrq_nxt      = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!HLDA) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    HRQ        = r_hrq;
    DACK       = ~(r_grant ^ {4{DACK_SENSE_HIGH}});
    CH_ACTIVE  = r_ch_active;
    CH_VALID   = r_ch_valid;
    REQ_STATUS = r_req_status;
    SW_REQ_CLR = r_sw_clr;
    DBG_STATE  = r_state;
  end

endmodule

// File: tb/tb_dma_priority_arb.sv
// Directed bench for dma_priority_arb: hand-computed expectations for grant, priority,
// polarity, software requests, withdrawal, abort and asynchronous reset.
module tb_dma_priority_arb;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] MASK;
  logic [3:0] SW_REQ;
  logic       CMD_DISABLE;
  logic       CMD_ROT_PRIO;
  logic       DREQ_SENSE_LOW;
  logic       DACK_SENSE_HIGH;
  logic       SVC_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] CH_ACTIVE;
  logic       CH_VALID;
  logic [3:0] REQ_STATUS;
  logic [3:0] SW_REQ_CLR;
  logic [1:0] DBG_STATE;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  dma_priority_arb #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .MASK(MASK),
    .SW_REQ(SW_REQ), .CMD_DISABLE(CMD_DISABLE), .CMD_ROT_PRIO(CMD_ROT_PRIO),
    .DREQ_SENSE_LOW(DREQ_SENSE_LOW), .DACK_SENSE_HIGH(DACK_SENSE_HIGH),
    .SVC_DONE(SVC_DONE), .HRQ(HRQ), .DACK(DACK), .CH_ACTIVE(CH_ACTIVE),
    .CH_VALID(CH_VALID), .REQ_STATUS(REQ_STATUS), .SW_REQ_CLR(SW_REQ_CLR),
    .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_hrq();
    for (int i = 0; i < 20; i++) begin
      if (HRQ) break;
      tick();
    end
    chk("hrq_rise", 8'(HRQ), 8'd1);
  endtask

  task automatic grant(input logic [1:0] exp_ch);
    HLDA = 1'b1;
    tick();
    chk("grant_valid", 8'(CH_VALID), 8'd1);
    chk("grant_ch", 8'(CH_ACTIVE), 8'(exp_ch));
  endtask

  task automatic finish_svc();
    SVC_DONE = 1'b1;
    tick();
    SVC_DONE = 1'b0;
    chk("done_hrq", 8'(HRQ), 8'd0);
    chk("done_state", 8'(DBG_STATE), 8'(ST_RELEASE));
    HLDA = 1'b0;
    tick();
    chk("release_idle", 8'(DBG_STATE), 8'(ST_IDLE));
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = '0; HLDA = 1'b0; MASK = '0; SW_REQ = '0;
    CMD_DISABLE = 1'b0; CMD_ROT_PRIO = 1'b0; DREQ_SENSE_LOW = 1'b0;
    DACK_SENSE_HIGH = 1'b0; SVC_DONE = 1'b0;
    #3;
    chk("rst_hrq", 8'(HRQ), 8'd0);
    chk("rst_dack", 8'(DACK), 8'hf);
    chk("rst_valid", 8'(CH_VALID), 8'd0);
    chk("rst_ch", 8'(CH_ACTIVE), 8'd0);
    chk("rst_status", 8'(REQ_STATUS), 8'd0);
    chk("rst_swclr", 8'(SW_REQ_CLR), 8'd0);
    chk("rst_state", 8'(DBG_STATE), 8'(ST_IDLE));

    // Basic single-channel service and HRQ latency of three edges.
    @(negedge CLK);
    RESET_N = 1'b1;
    DREQ = 4'b0100;
    tick(); chk("lat_e1", 8'(HRQ), 8'd0);
    tick(); chk("lat_e2", 8'(HRQ), 8'd0);
    chk("lat_status", 8'(REQ_STATUS), 8'h4);
    tick(); chk("lat_e3", 8'(HRQ), 8'd1);
    chk("lat_state", 8'(DBG_STATE), 8'(ST_REQ));
    grant(2'd2);
    chk("ch2_dack", 8'(DACK), 8'hb);
    chk("ch2_hrq", 8'(HRQ), 8'd1);
    DREQ = 4'b0000;
    finish_svc();
    chk("ch2_dack_off", 8'(DACK), 8'hf);
    idle(3);

    // Fixed priority: ch1 beats ch3, then ch3 once ch1 drops.
    DREQ = 4'b1010;
    wait_hrq();
    grant(2'd1);
    DREQ = 4'b1000;
    finish_svc();
    wait_hrq();
    grant(2'd3);
    DREQ = 4'b0000;
    finish_svc();
    idle(3);

    // Rotating priority: order 0,1,2,3 then back to 0.
    CMD_ROT_PRIO = 1'b1;
    DREQ = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_hrq();
      grant(2'(s));
      if (s == 4) DREQ = 4'b0000;
      finish_svc();
    end
    CMD_ROT_PRIO = 1'b0;
    idle(3);

    // Masked hardware request ignored, software request granted and cleared.
    MASK = 4'b0001;
    DREQ = 4'b0001;
    idle(4);
    chk("mask_hrq", 8'(HRQ), 8'd0);
    SW_REQ = 4'b0001;
    tick(); chk("sw_hrq", 8'(HRQ), 8'd1);
    grant(2'd0);
    SVC_DONE = 1'b1;
    tick();
    SVC_DONE = 1'b0;
    chk("swclr_pulse", 8'(SW_REQ_CLR), 8'h1);
    tick();
    chk("swclr_end", 8'(SW_REQ_CLR), 8'h0);
    chk("rel_no_hrq", 8'(HRQ), 8'd0);
    SW_REQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    chk("sw_idle", 8'(DBG_STATE), 8'(ST_IDLE));
    DREQ = 4'b0000;
    idle(3);
    MASK = 4'b0000;

    // Inverted DREQ and DACK polarity.
    CMD_DISABLE = 1'b1;
    DREQ_SENSE_LOW = 1'b1;
    DREQ = 4'b1110;
    idle(3);
    chk("pol_status", 8'(REQ_STATUS), 8'h1);
    chk("pol_dis_hrq", 8'(HRQ), 8'd0);
    DACK_SENSE_HIGH = 1'b1;
    CMD_DISABLE = 1'b0;
    #1 chk("pol_dack_idle", 8'(DACK), 8'h0);
    wait_hrq();
    grant(2'd0);
    chk("pol_dack", 8'(DACK), 8'h1);
    finish_svc();
    CMD_DISABLE = 1'b1;
    DREQ_SENSE_LOW = 1'b0;
    DACK_SENSE_HIGH = 1'b0;
    DREQ = 4'b0000;
    idle(3);
    CMD_DISABLE = 1'b0;

    // Request withdrawn before HLDA.
    DREQ = 4'b0001;
    wait_hrq();
    DREQ = 4'b0000;
    tick(); chk("wd_hold1", 8'(HRQ), 8'd1);
    tick(); chk("wd_hold2", 8'(HRQ), 8'd1);
    tick(); chk("wd_drop", 8'(HRQ), 8'd0);
    chk("wd_state", 8'(DBG_STATE), 8'(ST_IDLE));
    idle(2);

    // Higher-priority request during REQ wins; grant not preempted; CPU abort.
    DREQ = 4'b0100;
    wait_hrq();
    DREQ = 4'b0101;
    idle(2);
    grant(2'd0);
    MASK = 4'b1111;
    CMD_DISABLE = 1'b1;
    DREQ = 4'b0000;
    tick();
    chk("hold_valid", 8'(CH_VALID), 8'd1);
    chk("hold_dack", 8'(DACK), 8'he);
    HLDA = 1'b0;
    tick();
    chk("abort_valid", 8'(CH_VALID), 8'd0);
    chk("abort_hrq", 8'(HRQ), 8'd0);
    chk("abort_state", 8'(DBG_STATE), 8'(ST_IDLE));
    chk("abort_swclr", 8'(SW_REQ_CLR), 8'h0);
    idle(3);
    MASK = 4'b0000;
    CMD_DISABLE = 1'b0;

    // SVC_DONE coinciding with HLDA fall is a normal completion.
    DREQ = 4'b0010;
    wait_hrq();
    grant(2'd1);
    DREQ = 4'b0000;
    SVC_DONE = 1'b1;
    HLDA = 1'b0;
    tick();
    SVC_DONE = 1'b0;
    chk("same_state", 8'(DBG_STATE), 8'(ST_RELEASE));
    chk("same_valid", 8'(CH_VALID), 8'd0);
    tick();
    chk("same_idle", 8'(DBG_STATE), 8'(ST_IDLE));
    SVC_DONE = 1'b1;
    tick();
    SVC_DONE = 1'b0;
    chk("stray_svc", 8'(DBG_STATE), 8'(ST_IDLE));
    idle(3);

    // Asynchronous reset in the middle of a grant.
    DREQ = 4'b1000;
    wait_hrq();
    grant(2'd3);
    chk("ch3_dack", 8'(DACK), 8'h7);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_hrq", 8'(HRQ), 8'd0);
    chk("arst_dack", 8'(DACK), 8'hf);
    chk("arst_valid", 8'(CH_VALID), 8'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    DREQ = 4'b0000;
    HLDA = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_priority_arb.md
Name: dma_priority_arb

Overview:
- Priority and bus-request stage of the 8237A-style DMA controller.
- Connects to the channel request/acknowledge pins (DREQ, DACK) and the CPU hold handshake (HRQ, HLDA).
- Takes mask, software-request and command-register control bits from the datapath and hands the granted channel to timing control.
- Timing control reports end of service back to this block.

Parameters:
SYNC_STAGES, 2, flop stages on each asynchronous DREQ line (legal values 2..3)

Ports:
CLK  input  1  system clock, all flops on rising edge
RESET_N  input  1  asynchronous active-low reset
DREQ  input  4  asynchronous channel requests, polarity set by DREQ_SENSE_LOW
HLDA  input  1  hold acknowledge from CPU, synchronous to CLK
MASK  input  4  mask register bits, 1 = channel hardware request ignored
SW_REQ  input  4  request register bits, software requests, not maskable
CMD_DISABLE  input  1  command bit 2, 1 = controller disabled
CMD_ROT_PRIO  input  1  command bit 4, 1 = rotating priority
DREQ_SENSE_LOW  input  1  command bit 6, 1 = DREQ active low
DACK_SENSE_HIGH  input  1  command bit 7, 1 = DACK active high
SVC_DONE  input  1  one-cycle pulse from timing control, service of active channel complete
HRQ  output  1  hold request to CPU
DACK  output  4  channel acknowledges, polarity per DACK_SENSE_HIGH
CH_ACTIVE  output  2  granted channel number
CH_VALID  output  1  1 while a channel is granted
REQ_STATUS  output  4  synchronized, polarity-corrected DREQ (status reg bits 7:4)
SW_REQ_CLR  output  4  one-cycle pulse clearing the serviced request register bit

Behaviour:
Reset:
- HRQ=0, CH_ACTIVE=0, CH_VALID=0, REQ_STATUS=0, SW_REQ_CLR=0.
- Internal grant vector = 0; rotation pointer = 0; synchronizers = 0 (inactive after polarity); state IDLE.

Request path:
- Raw DREQ passes through SYNC_STAGES flops, then XOR with DREQ_SENSE_LOW; the result is REQ_STATUS.
- req_eff = (REQ_STATUS & ~MASK) | SW_REQ.

DACK output:
- Combinational: DACK[i] = grant[i] XNOR DACK_SENSE_HIGH.
- With DACK_SENSE_HIGH=0 in reset, DACK=4'b1111 (all inactive).

Priority:
- Fixed (CMD_ROT_PRIO=0): ch0 highest, ch3 lowest; pointer forced to 0.
- Rotating: highest priority is pointer p, then p+1, p+2, p+3 mod 4.
- On service end with rotation enabled, p <= (CH_ACTIVE+1) mod 4, making the just-serviced channel lowest priority.

State machine:
- IDLE: if CMD_DISABLE=0 and req_eff!=0, then HRQ<=1 and go to REQ. Latency: HRQ rises at rising edge SYNC_STAGES+1 after DREQ is first sampled active; a SW_REQ rises HRQ at the next edge.
- REQ, req_eff==0 or CMD_DISABLE=1 while HLDA=0: HRQ<=0, return to IDLE.
- REQ, HLDA sampled 1: arbitrate req_eff at that same edge, register grant one-hot, CH_ACTIVE, CH_VALID=1, go to GRANT. DACK is visible after that edge. HRQ stays 1.
- REQ, HLDA=1 and req_eff==0: HRQ<=0, go to RELEASE without granting.
- GRANT: grant is held stable; DREQ changes, MASK changes and CMD_DISABLE do not preempt the grant.
- GRANT, SVC_DONE: clear grant and CH_VALID, HRQ<=0, pulse SW_REQ_CLR[CH_ACTIVE] if SW_REQ[CH_ACTIVE]=1, update pointer, go to RELEASE.
- GRANT, HLDA drops without SVC_DONE (CPU abort): clear grant and HRQ, no SW_REQ_CLR, no pointer update, go to IDLE.
- RELEASE: wait for HLDA=0, then IDLE. No new HRQ while HLDA is still high.
- SVC_DONE outside GRANT is ignored.

Boundary conditions:
- Simultaneous requests resolve by priority at the HLDA edge, not at the HRQ edge. A higher-priority request arriving during REQ wins.
- SVC_DONE and HLDA fall in the same cycle: treated as normal completion.
- RESET_N asserted mid-service: all outputs return to reset values immediately (asynchronously).

Test Plan:
- Reset, DREQ=4'b0100 held high -> HRQ=1 at edge 3; HLDA=1 -> DACK=4'b1011, CH_ACTIVE=2, CH_VALID=1; SVC_DONE -> HRQ=0 and DACK=4'b1111 next edge.
- Fixed priority, DREQ=4'b1010 -> ch1 granted; after SVC_DONE and HLDA cycle, ch3 granted.
- Rotating priority, DREQ=4'b1111 for 4 services -> grant order 0,1,2,3; pointer returns to 0.
- MASK=4'b0001, DREQ=4'b0001 -> HRQ stays 0; SW_REQ=4'b0001 -> ch0 granted; SW_REQ_CLR=4'b0001 pulses 1 cycle on SVC_DONE.
- DREQ_SENSE_LOW=1, DACK_SENSE_HIGH=1, DREQ=4'b1110 -> REQ_STATUS=4'b0001, DACK=4'b0001 after grant.
- Request withdrawn before HLDA -> HRQ drops and state returns to IDLE; RESET_N low during GRANT -> HRQ=0, DACK=4'b1111 immediately.
